// File: rtl/vrp_link_pkg.sv
// vrp_link_pkg: shared constants, types and helpers for the valid-ready-prime link.
package vrp_link_pkg;

  localparam int VRP_WIDTH_DEFAULT = 32;
  localparam int VRP_SKID_DEFAULT  = 8;
  localparam int VRP_DEPTH_DEFAULT = 16;

  // Smallest buffer that can absorb a full skid plus the input register beat
  // and still leave one slot of headroom for ready to reassert.
  function automatic int vrp_min_depth(input int skid);
    return skid + 2;
  endfunction

  // One link beat at the default payload width: frame-end flag over payload.
  typedef struct packed {
    logic                         last;
    logic [VRP_WIDTH_DEFAULT-1:0] data;
  } vrp_beat_t;

endpackage

// File: rtl/vrp_ring_mem.sv
// vrp_ring_mem: simple dual-port beat storage, synchronous write, asynchronous
// read so the head entry is visible in the same cycle (first-word fall-through).
module vrp_ring_mem #(
  parameter int  WIDTH = 33,
  parameter int  DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Store one beat per accepted write; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/vrp_link_receiver.sv
// vrp_link_receiver: receive end of a valid-ready-prime link.
// The remote beat is registered once, written into a ring buffer large enough
// to absorb the beats still in flight after link_ready falls, and presented
// locally as a first-word-fall-through valid/ready stream.
// Optional feature: define VRP_RX_ERR_COUNT_EN to add the err_count output
// (saturating count of dropped beats, cleared by clr_overflow).
module vrp_link_receiver
  import vrp_link_pkg::*;
#(
  parameter int WIDTH      = VRP_WIDTH_DEFAULT,
  parameter int DEPTH      = VRP_DEPTH_DEFAULT,
  parameter int SKID_SLOTS = VRP_SKID_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       link_data,
  input  logic                   link_last,
  input  logic                   link_valid,
  output logic                   link_ready,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_last,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [$clog2(DEPTH):0] occupancy,
`ifdef VRP_RX_ERR_COUNT_EN
  output logic [31:0]            err_count,
`endif
  output logic                   overflow,
  input  logic                   clr_overflow
);

  localparam int            AW         = $clog2(DEPTH);
  localparam int            CW         = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [CW-1:0] SKID_COUNT = CW'(SKID_SLOTS);

  logic             in_valid_q, in_valid_d;
  logic [WIDTH-1:0] in_data_q, in_data_d;
  logic             in_last_q, in_last_d;
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             link_ready_q, link_ready_d;
  logic             overflow_q, overflow_d;
  logic             rd_en, wr_en, drop;
  logic [WIDTH:0]   rd_beat;

  // Buffer control: accept a registered beat unless full with no read, track
  // occupancy, and derive next ready from post-update free space.
  always_comb begin
    in_valid_d   = link_valid;
    in_data_d    = link_data;
    in_last_d    = link_last;
    rd_en        = (count_q != '0) && i_ready;
    wr_en        = in_valid_q && ((count_q != FULL_COUNT) || rd_en);
    drop         = in_valid_q && (count_q == FULL_COUNT) && !rd_en;
    wptr_d       = wptr_q + AW'(wr_en);
    rptr_d       = rptr_q + AW'(rd_en);
    count_d      = count_q;
    if (wr_en && !rd_en) begin
      count_d = count_q + CW'(1);
    end else if (rd_en && !wr_en) begin
      count_d = count_q - CW'(1);
    end
    link_ready_d = (FULL_COUNT - count_d) > SKID_COUNT;
    overflow_d   = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end
  end

  // Control state with synchronous reset; in-flight and buffered beats are discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_valid_q   <= 1'b0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      link_ready_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      in_valid_q   <= in_valid_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      link_ready_q <= link_ready_d;
      overflow_q   <= overflow_d;
    end
  end

  // Payload capture; meaningless unless in_valid_q is set, so no reset.
  always_ff @(posedge clk) begin
    in_data_q <= in_data_d;
    in_last_q <= in_last_d;
  end

  vrp_ring_mem #(
    .WIDTH (WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wptr_q),
    .wr_data ({in_last_q, in_data_q}),
    .rd_addr (rptr_q),
    .rd_data (rd_beat)
  );

`ifdef VRP_RX_ERR_COUNT_EN
  logic [31:0] err_count_q, err_count_d;

  // Dropped-beat counter: clear beats increment, saturates at all-ones.
  always_comb begin
    err_count_d = err_count_q;
    if (clr_overflow) begin
      err_count_d = '0;
    end else if (drop && (err_count_q != '1)) begin
      err_count_d = err_count_q + 32'd1;
    end
  end

  // Counter register, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count_q <= '0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
`endif

  assign link_ready = link_ready_q;
  assign o_valid    = (count_q != '0);
  assign o_data     = rd_beat[WIDTH-1:0];
  assign o_last     = rd_beat[WIDTH];
  assign occupancy  = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_vrp_link_receiver.sv
// tb_vrp_link_receiver: randomized and directed stimulus against a queue-based
// reference model of the link receiver, checked every cycle on the falling edge.
`timescale 1ns/1ps
module tb_vrp_link_receiver;
  import vrp_link_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int SKID  = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] link_data;
  logic             link_last;
  logic             link_valid;
  logic             link_ready;
  logic [WIDTH-1:0] o_data;
  logic             o_last;
  logic             o_valid;
  logic             i_ready;
  logic [4:0]       occupancy;
  logic             overflow;
  logic             clr_overflow;
`ifdef VRP_RX_ERR_COUNT_EN
  logic [31:0]      err_count;
`endif

  vrp_link_receiver #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SKID_SLOTS(SKID)) dut (
    .clk          (clk),
    .reset        (reset),
    .link_data    (link_data),
    .link_last    (link_last),
    .link_valid   (link_valid),
    .link_ready   (link_ready),
    .o_data       (o_data),
    .o_last       (o_last),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .occupancy    (occupancy),
`ifdef VRP_RX_ERR_COUNT_EN
    .err_count    (err_count),
`endif
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  vrp_beat_t   mq[$];      // beats stored, oldest first
  bit          m_pv;       // a beat is sitting in the input register
  vrp_beat_t   m_pb;
  bit          m_ovf;
  bit          m_rdy;
  logic [31:0] m_err;
  bit          m_rd, m_drop;

  initial begin
    m_pv = 0; m_ovf = 0; m_rdy = 0; m_err = '0;
    forever begin
      @(posedge clk);
      if (reset) begin
        mq.delete();
        m_pv = 0; m_ovf = 0; m_rdy = 0; m_err = '0;
      end else begin
        m_rd   = (mq.size() != 0) && i_ready;
        m_drop = 0;
        if (m_rd) void'(mq.pop_front());
        if (m_pv) begin
          if (mq.size() < DEPTH) mq.push_back(m_pb);
          else m_drop = 1;
        end
        if (m_drop) m_ovf = 1;
        else if (clr_overflow) m_ovf = 0;
        if (clr_overflow) m_err = '0;
        else if (m_drop && m_err != 32'hFFFF_FFFF) m_err = m_err + 1;
        m_rdy = (DEPTH - mq.size()) > SKID;
        m_pv  = link_valid;
        m_pb  = {link_last, link_data};
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("o_valid", o_valid, mq.size() != 0);
        if (mq.size() != 0) begin
          chk("o_data", o_data, mq[0].data);
          chk("o_last", o_last, mq[0].last);
        end
        chk("occupancy", occupancy, mq.size());
        chk("link_ready", link_ready, m_rdy);
        chk("overflow", overflow, m_ovf);
`ifdef VRP_RX_ERR_COUNT_EN
        chk("err_count", err_count, m_err);
`endif
      end
    end
  end

  // ---------------- remote with delayed view of link_ready ----------------
  logic rq[$];

  task automatic tick();
    @(posedge clk);
    #1;
    rq.push_back(link_ready);
    if (rq.size() > 8) void'(rq.pop_front());
  endtask

  // Remote may send this cycle only if ready was high 7 cycles ago, i.e. the
  // ready decision made 8 cycles before the beat.
  function automatic bit allowed();
    return (rq.size() == 8) ? rq[0] : 1'b0;
  endfunction

  int n;

  initial begin
    reset = 1; link_valid = 0; link_data = '0; link_last = 0;
    i_ready = 0; clr_overflow = 0;
    repeat (3) tick();
    reset = 0;
    chk_en = 1;
    @(negedge clk);
    chk("reset link_ready", link_ready, 1'b0);
    chk("reset occupancy", occupancy, 5'd0);
    chk("reset o_valid", o_valid, 1'b0);
    tick();
    @(negedge clk);
    chk("post-reset link_ready", link_ready, 1'b1);
    tick();

    // Continuous stream of 100 beats, consumer always ready.
    i_ready = 1;
    for (int i = 0; i < 100; i++) begin
      link_valid = 1; link_data = i; link_last = (i % 10 == 9);
      if (i < 2) begin
        @(negedge clk);
        chk("latency o_valid early", o_valid, 1'b0);
      end else if (i == 2) begin
        @(negedge clk);
        chk("latency o_valid at 2", o_valid, 1'b1);
        chk("latency first data", o_data, 32'd0);
      end
      tick();
    end
    link_valid = 0;
    repeat (4) tick();
    @(negedge clk);
    chk("stream drained", occupancy, 5'd0);
    $display("[TB] stream: 100 beats sent");

    // Backpressure with a well-behaved remote.
    i_ready = 0; n = 0;
    for (int c = 0; c < 40; c++) begin
      link_valid = allowed() && (n < 20);
      if (link_valid) begin link_data = 1000 + n; link_last = (n == 19); n++; end
      tick();
    end
    link_valid = 0;
    @(negedge clk);
    chk("bp occupancy full", occupancy, 5'd16);
    chk("bp link_ready low", link_ready, 1'b0);
    chk("bp no overflow", overflow, 1'b0);
    i_ready = 1;
    for (int c = 0; c < 60; c++) begin
      link_valid = allowed() && (n < 20);
      if (link_valid) begin link_data = 1000 + n; link_last = (n == 19); n++; end
      tick();
    end
    link_valid = 0;
    @(negedge clk);
    chk("bp drained", occupancy, 5'd0);
    $display("[TB] backpressure: 20 beats, remote obeys ready");

    // Contract violation: 20 beats into a stalled consumer.
    i_ready = 0;
    for (int i = 0; i < 20; i++) begin
      link_valid = 1; link_data = 2000 + i; link_last = (i == 19);
      tick();
    end
    link_valid = 0;
    repeat (3) tick();
    @(negedge clk);
    chk("violation occupancy", occupancy, 5'd16);
    chk("violation overflow", overflow, 1'b1);
`ifdef VRP_RX_ERR_COUNT_EN
    chk("violation err_count", err_count, 32'd4);
`endif
    $display("[TB] violation: 20 beats ignoring ready");

    // One more drop.
    link_valid = 1; link_data = 2100; link_last = 0;
    tick();
    link_valid = 0;
    tick();
    @(negedge clk);
`ifdef VRP_RX_ERR_COUNT_EN
    chk("extra drop err_count", err_count, 32'd5);
`endif
    chk("extra drop overflow", overflow, 1'b1);

    // Clear coincident with a drop: flag stays, counter clears.
    link_valid = 1; link_data = 2101;
    tick();
    link_valid = 0; clr_overflow = 1;
    tick();
    clr_overflow = 0;
    @(negedge clk);
    chk("clr+drop overflow", overflow, 1'b1);
`ifdef VRP_RX_ERR_COUNT_EN
    chk("clr+drop err_count", err_count, 32'd0);
`endif
    clr_overflow = 1;
    tick();
    clr_overflow = 0;
    @(negedge clk);
    chk("clr alone overflow", overflow, 1'b0);
    $display("[TB] overflow clear sequence");

    // Full buffer with simultaneous read and write.
    link_valid = 1; link_data = 2200; link_last = 1;
    tick();
    link_valid = 0; i_ready = 1;
    tick();
    i_ready = 0;
    @(negedge clk);
    chk("full rw occupancy", occupancy, 5'd16);
    chk("full rw overflow", overflow, 1'b0);
    i_ready = 1;
    repeat (20) tick();
    @(negedge clk);
    chk("full rw drained", occupancy, 5'd0);
    $display("[TB] full buffer read+write");

    // Reset mid-frame.
    i_ready = 0;
    for (int i = 0; i < 6; i++) begin
      link_valid = 1; link_data = 3000 + i; link_last = 0;
      tick();
    end
    link_valid = 0; reset = 1;
    tick();
    reset = 0;
    @(negedge clk);
    chk("midreset occupancy", occupancy, 5'd0);
    chk("midreset o_valid", o_valid, 1'b0);
    chk("midreset link_ready", link_ready, 1'b0);
    tick();
    @(negedge clk);
    chk("after reset link_ready", link_ready, 1'b1);
    i_ready = 1;
    for (int i = 0; i < 4; i++) begin
      link_valid = 1; link_data = 4000 + i; link_last = (i == 3);
      tick();
    end
    link_valid = 0;
    repeat (4) tick();
    $display("[TB] reset mid-frame, fresh frame of 4");

    // Randomized traffic with a contract-abiding remote.
    for (int c = 0; c < 400; c++) begin
      i_ready      = ($urandom_range(0, 1) == 1);
      link_valid   = allowed() && ($urandom_range(0, 3) != 0);
      link_data    = $urandom;
      link_last    = ($urandom_range(0, 3) == 0);
      clr_overflow = ($urandom_range(0, 31) == 0);
      tick();
    end
    link_valid = 0; clr_overflow = 0; i_ready = 1;
    repeat (24) tick();
    @(negedge clk);
    chk("random no overflow", overflow, 1'b0);
    chk("random drained", occupancy, 5'd0);
    $display("[TB] random: 400 cycles");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
